// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the multi-read-port register file.
package regfile_mp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  // Widest word the byte-merge helper handles; callers size-cast in and out.
  localparam int unsigned RF_MAX_W = 256;

  function automatic logic [RF_MAX_W-1:0] byte_merge(
    input logic [RF_MAX_W-1:0]   old_w,
    input logic [RF_MAX_W-1:0]   new_w,
    input logic [RF_MAX_W/8-1:0] be
  );
    logic [RF_MAX_W-1:0] res;
    res = old_w;
    for (int b = 0; b < int'(RF_MAX_W / 8); b++) begin
      if (be[b]) begin
        res[b*8 +: 8] = new_w[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_w[b*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_mp_clr.sv
// Clear engine: walks every entry once writing zero, then pulses clr_done_o.
module regfile_mp_clr
  import regfile_mp_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req_i,
  output logic              sweep_we_o,
  output logic [ADDR_W-1:0] sweep_addr_o,
  output logic              clr_busy_o,
  output logic              clr_done_o
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              busy_q;
  logic              done_q;

  // Busy stays up for one extra cycle after DONE so requests are still ignored then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          ptr_q  <= '0;
          if (clr_req_i && !busy_q) begin
            state_q <= SWEEP;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        SWEEP: begin
          busy_q <= 1'b1;
          done_q <= 1'b0;
          if (ptr_q == LAST_PTR) begin
            state_q <= DONE;
            ptr_q   <= '0;
          end else begin
            state_q <= SWEEP;
            ptr_q   <= ptr_q + ADDR_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ptr_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sweep_we_o   = (state_q == SWEEP);
  assign sweep_addr_o = ptr_q;
  assign clr_busy_o   = busy_q;
  assign clr_done_o   = done_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-enabled writes and a hardware clear sweep.
// Define RF_BYPASS_EN to forward same-edge writes into the read registers.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int NRD    = 2,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);

  if (DATA_W % 8 != 0) begin : g_chk_w
    $error("regfile_mp: DATA_W must be a multiple of 8");
  end
  if (DATA_W > int'(RF_MAX_W)) begin : g_chk_wmax
    $error("regfile_mp: DATA_W exceeds byte_merge width");
  end
  if (DEPTH < 2) begin : g_chk_d
    $error("regfile_mp: DEPTH must be at least 2");
  end
  if (NRD < 1) begin : g_chk_n
    $error("regfile_mp: NRD must be at least 1");
  end

  // One extra bit so DEPTH itself is representable for range checks.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              sweep_we_s;
  logic [ADDR_W-1:0] sweep_addr_s;
  logic              clr_busy_s;
  logic              clr_done_s;
  logic              ext_ok_s;
  logic [DATA_W-1:0] merged_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;

  regfile_mp_clr #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_req_i    (clr_req),
    .sweep_we_o   (sweep_we_s),
    .sweep_addr_o (sweep_addr_s),
    .clr_busy_o   (clr_busy_s),
    .clr_done_o   (clr_done_s)
  );

  assign clr_busy = clr_busy_s;
  assign clr_done = clr_done_s;

  // Single write port: the sweep wins, external writes only when idle and in range.
  always_comb begin
    ext_ok_s = we && !clr_busy_s && ({1'b0, waddr} < DEPTH_C) && (wbe != '0);
    if ({1'b0, waddr} < DEPTH_C) begin
      merged_s = DATA_W'(byte_merge(RF_MAX_W'(mem_q[waddr]), RF_MAX_W'(wdata),
                                    (RF_MAX_W / 8)'(wbe)));
    end else begin
      merged_s = '0;
    end
    if (sweep_we_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = sweep_addr_s;
      wr_data_s = '0;
    end else if (ext_ok_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = waddr;
      wr_data_s = merged_s;
    end else begin
      wr_en_s   = 1'b0;
      wr_addr_s = '0;
      wr_data_s = '0;
    end
  end

  // Storage is deliberately not reset; it is initialised by writes or the sweep.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_addr_s] <= wr_data_s;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    logic [DATA_W-1:0] rd_word_d;
    logic [DATA_W-1:0] rd_q;

    assign ra_s = raddr[i*ADDR_W +: ADDR_W];

    always_comb begin
      if ({1'b0, ra_s} >= DEPTH_C) begin
        rd_word_d = '0;
`ifdef RF_BYPASS_EN
      end else if (wr_en_s && (wr_addr_s == ra_s)) begin
        rd_word_d = wr_data_s;
`endif
      end else begin
        rd_word_d = mem_q[ra_s];
      end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_word_d;
      end
    end

    assign rdata[i*DATA_W +: DATA_W] = rd_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (DEPTH=12, NRD=3, DATA_W=32): a behavioural model
// pushes expected outputs per edge, a monitor pops and compares after each edge.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int DP = 12;
  localparam int NR = 3;
  localparam int AW = 4;
  localparam int BW = DW / 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             we = 1'b0;
  logic [AW-1:0]    waddr = '0;
  logic [DW-1:0]    wdata = '0;
  logic [BW-1:0]    wbe = '0;
  logic [NR*AW-1:0] raddr = '0;
  logic [NR*DW-1:0] rdata;
  logic             clr_req = 1'b0;
  logic             clr_busy;
  logic             clr_done;

  regfile_mp #(.DATA_W(DW), .DEPTH(DP), .NRD(NR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .wbe      (wbe),
    .raddr    (raddr),
    .rdata    (rdata),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    care;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t          exp_q [$];
  exp_t          mon_e;
  logic [DW-1:0] m_mem   [DP];
  bit            m_known [DP];
  bit            m_busy = 1'b0;
  int            m_t = 0;
  int            n_vec = 0;
  int            n_bad = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rd_port(input int p);
    return rdata[p*DW +: DW];
  endfunction

  // Reference model: evaluates one clock edge from the current inputs.
  task automatic model_edge();
    exp_t          e;
    bit            wr, wknown;
    int            wa, a;
    logic [DW-1:0] wv;
    wr = 1'b0; wknown = 1'b0; wa = 0; wv = '0;
    if (m_busy && m_t < DP) begin
      wr = 1'b1; wa = m_t; wv = '0; wknown = 1'b1;
    end else if (!m_busy && we && int'(waddr) < DP && wbe != '0) begin
      wr = 1'b1; wa = int'(waddr); wv = m_mem[wa];
      for (int b = 0; b < BW; b++) if (wbe[b]) wv[8*b +: 8] = wdata[8*b +: 8];
      wknown = m_known[wa] || (wbe == {BW{1'b1}});
    end
    for (int p = 0; p < NR; p++) begin
      a = int'(raddr[p*AW +: AW]);
      if (a >= DP) begin
        e.rd[p*DW +: DW] = '0; e.care[p] = 1'b1;
`ifdef RF_BYPASS_EN
      end else if (wr && wa == a) begin
        e.rd[p*DW +: DW] = wv; e.care[p] = wknown;
`endif
      end else begin
        e.rd[p*DW +: DW] = m_mem[a]; e.care[p] = m_known[a];
      end
    end
    if (wr) begin
      m_mem[wa] = wv; m_known[wa] = wknown;
    end
    if (m_busy) begin
      m_t++;
      e.done = (m_t == DP + 1);
      m_busy = (m_t <= DP + 1);
    end else if (clr_req) begin
      m_t = 0; m_busy = 1'b1; e.done = 1'b0;
    end else begin
      e.done = 1'b0;
    end
    e.busy = m_busy;
    exp_q.push_back(e);
  endtask

  // Monitor: compares the DUT against the oldest expectation just after each edge.
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      for (int p = 0; p < NR; p++)
        if (mon_e.care[p]) chk($sformatf("rdata%0d", p), rd_port(p), mon_e.rd[p*DW +: DW]);
      chk("clr_busy", DW'(clr_busy), DW'(mon_e.busy));
      chk("clr_done", DW'(clr_done), DW'(mon_e.done));
    end
  end

  task automatic step();
    model_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    we = 1'b1; waddr = AW'(a); wdata = d; wbe = be;
    step();
    we = 1'b0; wbe = '0;
  endtask

  task automatic set_all_raddr(input int a);
    for (int p = 0; p < NR; p++) raddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    m_busy = 1'b0; m_t = 0;
    exp_q.delete();
    #1;
    for (int p = 0; p < NR; p++) chk($sformatf("rst_rdata%0d", p), rd_port(p), '0);
    chk("rst_busy", DW'(clr_busy), '0);
    chk("rst_done", DW'(clr_done), '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_rdata0", rd_port(0), '0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int nb, nd;
    for (int i = 0; i < DP; i++) begin m_mem[i] = '0; m_known[i] = 1'b0; end
    #1 apply_reset();

    // Basic write then read
    wr(3, 32'h0000_0032, 4'hF);
    raddr[0 +: AW] = AW'(3);
    step();
    chk("wr_rd_3", rd_port(0), 32'h0000_0032);

    // Byte enables and empty enable
    wr(5, 32'h0000_ABCD, 4'hF);
    wr(5, 32'h0000_1234, 4'b0001);
    raddr[0 +: AW] = AW'(5);
    step();
    chk("be_5", rd_port(0), 32'h0000_AB34);
    we = 1'b1; waddr = AW'(5); wdata = 32'hFFFF_FFFF; wbe = '0;
    step();
    we = 1'b0;
    step();
    chk("be0_5", rd_port(0), 32'h0000_AB34);

    // Same-edge write/read hazard
    wr(9, 32'h0000_0011, 4'hF);
    set_all_raddr(9);
    we = 1'b1; waddr = AW'(9); wdata = 32'h0000_0043; wbe = 4'hF;
    step();
    we = 1'b0; wbe = '0;
`ifdef RF_BYPASS_EN
    chk("hz_p0", rd_port(0), 32'h0000_0043);
    chk("hz_p1", rd_port(1), 32'h0000_0043);
`else
    chk("hz_p0", rd_port(0), 32'h0000_0011);
    chk("hz_p1", rd_port(1), 32'h0000_0011);
`endif
    step();
    chk("hz_next", rd_port(1), 32'h0000_0043);

    // Randomised traffic against the model
    for (int i = 0; i < DP; i++) wr(i, $urandom, 4'hF);
    for (int n = 0; n < 400; n++) begin
      we      = 1'($urandom_range(0, 1));
      waddr   = AW'($urandom_range(0, 15));
      wdata   = $urandom;
      wbe     = BW'($urandom_range(0, 15));
      clr_req = ($urandom_range(0, 49) == 0);
      for (int p = 0; p < NR; p++) raddr[p*AW +: AW] = AW'($urandom_range(0, 15));
      step();
    end
    we = 1'b0; clr_req = 1'b0; wbe = '0;
    repeat (DP + 4) step();

    // Full sweep with a dropped write and an ignored second request
    for (int i = 0; i < DP; i++) wr(i, 32'hFFFF_FFFF, 4'hF);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    nb = int'(clr_busy); nd = int'(clr_done);
    for (int i = 0; i < 30; i++) begin
      raddr[0 +: AW] = AW'(i % DP);
      if (i == 2) begin
        we = 1'b1; waddr = AW'(2); wdata = 32'h0000_5555; wbe = 4'hF; clr_req = 1'b1;
      end else begin
        we = 1'b0; wbe = '0; clr_req = 1'b0;
      end
      step();
      nb += int'(clr_busy); nd += int'(clr_done);
    end
    chk("sweep_busy_cycles", DW'(nb), DW'(DP + 2));
    chk("sweep_done_pulses", DW'(nd), DW'(1));
    for (int i = 0; i < DP; i++) begin
      raddr[0 +: AW] = AW'(i);
      step();
      chk($sformatf("swept_%0d", i), rd_port(0), '0);
    end

    // Reset in the middle of a sweep
    for (int i = 0; i < DP; i++) wr(i, 32'hFFFF_FFFF, 4'hF);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (4) step();
    apply_reset();
    nd = 0;
    for (int i = 0; i < DP; i++) begin
      raddr[0 +: AW] = AW'(i);
      step();
      nd += int'(clr_done);
      chk($sformatf("part_%0d", i), rd_port(0), (i < 4) ? 32'h0 : 32'hFFFF_FFFF);
    end
    chk("part_no_done", DW'(nd), '0);

    // Out-of-range accesses and independent ports
    wr(0, 32'hA000_0000, 4'hF);
    wr(7, 32'h0B00_0007, 4'hF);
    wr(11, 32'h00C0_000B, 4'hF);
    wr(1, 32'h1111_1111, 4'hF);
    wr(13, 32'hDEAD_BEEF, 4'hF);
    set_all_raddr(14);
    step();
    for (int p = 0; p < NR; p++) chk($sformatf("oor_p%0d", p), rd_port(p), '0);
    raddr[0 +: AW] = AW'(0); raddr[AW +: AW] = AW'(7); raddr[2*AW +: AW] = AW'(11);
    step();
    chk("ind_p0", rd_port(0), 32'hA000_0000);
    chk("ind_p1", rd_port(1), 32'h0B00_0007);
    chk("ind_p2", rd_port(2), 32'h00C0_000B);
    set_all_raddr(1);
    step();
    chk("oor_no_alias", rd_port(0), 32'h1111_1111);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
